// File: rtl/i2c_target_regif_pkg.sv
// Shared types and constants for the I2C target register interface.
package i2c_target_regif_pkg;

  // Protocol phases of the target, from address match to end of transfer.
  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_SUB,
    S_SUB_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RD_MACK,
    S_WAIT_STOP
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h70;

  // Bus level carried in an acknowledge slot.
  localparam logic ACK = 1'b0;
  localparam logic NAK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for a raw I2C pin plus rise/fall detection.
// Flops reset to 1 so an idle (pulled-up) bus shows no edge out of reset.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift chain: stage 0 takes the pin, the last stage feeds the edge detector.
  always_comb begin
    sync_d[0] = d_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target front end: START/STOP decode, device address match, sub-address
// capture, write strobes and read fetches with sub-address auto-increment.
// SDA is open-drain: sda_oe=1 pulls low, otherwise the line is released.
module i2c_target_regif
  import i2c_target_regif_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       bus_active
);

  logic sda, sda_rise, sda_fall;
  logic scl, scl_rise, scl_fall;
  logic start, stop;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .clk(clk), .rst_n(rst_n), .d_in(sda_in),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(clk), .rst_n(rst_n), .d_in(scl_in),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       sda_oe_q, sda_oe_d;
  logic       bus_active_q, bus_active_d;
  logic       ack_phase_q, ack_phase_d;  // 0: ACK not yet driven, 1: ACK on the bus
  logic       rw_q, rw_d;
  logic       rd_fire;
  logic [7:0] byte_in;

  // Next-state and output decode; START/STOP override any bit activity.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_we_d     = 1'b0;
    sda_oe_d     = sda_oe_q;
    bus_active_d = bus_active_q;
    ack_phase_d  = ack_phase_q;
    rw_d         = rw_q;
    rd_fire      = 1'b0;
    byte_in      = {shift_q[6:0], sda};

    // Auto-increment lands the cycle after the write strobe.
    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;

    if (start) begin
      state_d      = S_ADDR;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      bus_active_d = 1'b1;
      ack_phase_d  = 1'b0;
    end else if (stop) begin
      state_d      = S_IDLE;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      bus_active_d = 1'b0;
      ack_phase_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_SUB, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              case (state_q)
                S_ADDR: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    state_d = S_ADDR_ACK;
                    rw_d    = byte_in[0];
                  end else begin
                    state_d = S_WAIT_STOP;
                  end
                end
                S_SUB: begin
                  reg_addr_d = byte_in;
                  state_d    = S_SUB_ACK;
                end
                default: begin
                  reg_wdata_d = byte_in;
                  reg_we_d    = 1'b1;
                  state_d     = S_WDATA_ACK;
                end
              endcase
            end
          end
        end
        S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = ~ACK;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              bit_cnt_d   = 4'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                // The ACK-release fall also begins the first read byte.
                state_d  = S_RDATA;
                rd_fire  = 1'b1;
                shift_d  = reg_rdata;
                sda_oe_d = ~reg_rdata[7];
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_SUB;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              // First fall after a master ACK: fetch the next byte.
              rd_fire  = 1'b1;
              shift_d  = reg_rdata;
              sda_oe_d = ~reg_rdata[7];
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_MACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_RD_MACK: begin
          if (scl_rise) begin
            if (sda == NAK) begin
              state_d = S_WAIT_STOP;
            end else begin
              reg_addr_d = reg_addr_q + 8'd1;
              bit_cnt_d  = 4'd0;
              state_d    = S_RDATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      reg_addr_q   <= 8'd0;
      reg_wdata_q  <= 8'd0;
      reg_we_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      bus_active_q <= 1'b0;
      ack_phase_q  <= 1'b0;
      rw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_we_q     <= reg_we_d;
      sda_oe_q     <= sda_oe_d;
      bus_active_q <= bus_active_d;
      ack_phase_q  <= ack_phase_d;
      rw_q         <= rw_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_rd     = rd_fire;
  assign bus_active = bus_active_q;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: bit-banged I2C master with a wired-AND SDA,
// scoreboard queues for register strobes checked by an independent monitor.
module tb_i2c_target_regif;

  localparam int Q = 4;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sda_m = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_in, scl_in;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_rd, bus_active;

  int checks = 0;
  int passes = 0;

  logic [15:0] exp_wr[$];  // {addr, data}
  logic [7:0]  exp_rd[$];  // addr at fetch

  always #5 clk = ~clk;

  assign sda_in    = sda_m & ~sda_oe;
  assign scl_in    = scl_m;
  assign reg_rdata = ~reg_addr;

  i2c_target_regif dut (
    .clk(clk), .rst_n(rst_n), .sda_in(sda_in), .scl_in(scl_in),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .bus_active(bus_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && reg_we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        $display("FAIL unexpected_we: got addr 0x%02h data 0x%02h, expected no write", reg_addr, reg_wdata);
      end else begin
        logic [15:0] e;
        e = exp_wr.pop_front();
        $display("write strobe addr 0x%02h data 0x%02h", reg_addr, reg_wdata);
        check("we_addr", {24'd0, reg_addr}, {24'd0, e[15:8]});
        check("we_data", {24'd0, reg_wdata}, {24'd0, e[7:0]});
      end
    end
    if (rst_n && reg_rd) begin
      if (exp_rd.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rd: got addr 0x%02h, expected no read", reg_addr);
      end else begin
        logic [7:0] e;
        e = exp_rd.pop_front();
        $display("read fetch addr 0x%02h", reg_addr);
        check("rd_addr", {24'd0, reg_addr}, {24'd0, e});
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    scl_m = 1'b0;
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_in; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    $display("master wrote 0x%02h, ack bit %0d", d, a);
    check(name, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] exp_d, input string name);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(mack);
    $display("master read 0x%02h, sent ack bit %0d", d, mack);
    check(name, {24'd0, d}, {24'd0, exp_d});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic b;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    check("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
    check("rst_bus_active", {31'd0, bus_active}, 32'd0);
    check("rst_strobes", {30'd0, reg_we, reg_rd}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Two-byte write with auto-increment
    exp_wr.push_back({8'h0A, 8'h55});
    exp_wr.push_back({8'h0B, 8'h1F});
    i2c_start();
    check("bus_active_start", {31'd0, bus_active}, 32'd1);
    write_byte(8'hE0, 1'b0, "t1_addr_ack");
    write_byte(8'h0A, 1'b0, "t1_sub_ack");
    write_byte(8'h55, 1'b0, "t1_d0_ack");
    write_byte(8'h1F, 1'b0, "t1_d1_ack");
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t1_bus_active_stop", {31'd0, bus_active}, 32'd0);
    check("t1_final_addr", {24'd0, reg_addr}, 32'h0C);

    // Increment across 0x7F and wrap at 0xFF
    exp_wr.push_back({8'h7F, 8'hFA});
    exp_wr.push_back({8'h80, 8'h4D});
    i2c_start();
    write_byte(8'hE0, 1'b0, "t2_addr_ack");
    write_byte(8'h7F, 1'b0, "t2_sub_ack");
    write_byte(8'hFA, 1'b0, "t2_d0_ack");
    write_byte(8'h4D, 1'b0, "t2_d1_ack");
    i2c_stop();
    exp_wr.push_back({8'hFF, 8'h11});
    exp_wr.push_back({8'h00, 8'h22});
    i2c_start();
    write_byte(8'hE0, 1'b0, "t2w_addr_ack");
    write_byte(8'hFF, 1'b0, "t2w_sub_ack");
    write_byte(8'h11, 1'b0, "t2w_d0_ack");
    write_byte(8'h22, 1'b0, "t2w_d1_ack");
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t2_wrap_addr", {24'd0, reg_addr}, 32'h01);

    // Sub-address write, repeated START, two-byte read
    exp_rd.push_back(8'h7E);
    exp_rd.push_back(8'h7F);
    i2c_start();
    write_byte(8'hE0, 1'b0, "t3_addr_ack");
    write_byte(8'h7E, 1'b0, "t3_sub_ack");
    i2c_start();
    write_byte(8'hE1, 1'b0, "t3_raddr_ack");
    read_byte(1'b0, 8'h81, "t3_rd0");
    read_byte(1'b1, 8'h80, "t3_rd1");
    repeat (8) @(negedge clk);
    check("t3_wait_stop_active", {31'd0, bus_active}, 32'd1);
    check("t3_wait_stop_oe", {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t3_final_addr", {24'd0, reg_addr}, 32'h7F);

    // Wrong device address: NAK, later bytes ignored
    i2c_start();
    write_byte(8'hE2, 1'b1, "t4_addr_nak");
    write_byte(8'h33, 1'b1, "t4_data_ignored");
    i2c_stop();

    // STOP inside a data byte discards it
    i2c_start();
    write_byte(8'hE0, 1'b0, "t5_addr_ack");
    write_byte(8'h20, 1'b0, "t5_sub_ack");
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t5_bus_active", {31'd0, bus_active}, 32'd0);
    check("t5_addr", {24'd0, reg_addr}, 32'h20);

    // Read from the retained sub-address, then async reset mid-byte
    exp_rd.push_back(8'h20);
    i2c_start();
    write_byte(8'hE1, 1'b0, "t6_raddr_ack");
    read_bit(b);
    check("t6_bit7", {31'd0, b}, 32'd1);
    read_bit(b);
    check("t6_bit6", {31'd0, b}, 32'd1);
    check("t6_oe_before_rst", {31'd0, sda_oe}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_oe_async", {31'd0, sda_oe}, 32'd0);
    check("t6_addr_rst", {24'd0, reg_addr}, 32'd0);
    check("t6_bus_active_rst", {31'd0, bus_active}, 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_wr.push_back({8'h05, 8'h99});
    i2c_start();
    write_byte(8'hE0, 1'b0, "t6_post_addr_ack");
    write_byte(8'h05, 1'b0, "t6_post_sub_ack");
    write_byte(8'h99, 1'b0, "t6_post_d_ack");
    i2c_stop();
    repeat (8) @(negedge clk);
    check("t6_post_addr", {24'd0, reg_addr}, 32'h06);

    check("pending_writes", exp_wr.size(), 32'd0);
    check("pending_reads", exp_rd.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
